// File: rtl/msdf_tree_sched_pkg.sv
// ---------------------------------------------------------------------------
// msdf_tree_sched_pkg
// Shared definitions for the MSDF adder-tree scheduler slice:
//   DIGIT_W      width of one opaque MSDF digit
//   schedState_t issue FSM state encoding
//   clog2()      ceiling log2 used for parameter-derived widths
// ---------------------------------------------------------------------------
package msdf_tree_sched_pkg;

    localparam int DIGIT_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } schedState_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'd1 << result) < 32'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/msdf_tag_fifo.sv
// ---------------------------------------------------------------------------
// msdf_tag_fifo
// Small FIFO holding the requester tag of every operand set currently inside
// the adder tree. Head is visible combinationally; push and pop may happen in
// the same cycle (occupancy unchanged).
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push       write pushData at the tail
//   pushData   tag to store
//   pop        drop the head entry
//   popData    current head entry
//   full       DEPTH entries held
//   empty      no entries held
// ---------------------------------------------------------------------------
module msdf_tag_fifo
    import msdf_tree_sched_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic             pushEn_s;
    logic             popEn_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bumpPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign pushEn_s = push && ((count_r != CNT_FULL) || pop);
    assign popEn_s  = pop && (count_r != {CNT_W{1'b0}});

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign popData = mem_r[rdPtr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (pushEn_s) begin
                mem_r[wrPtr_r] <= pushData;
                wrPtr_r        <= bumpPtr(wrPtr_r);
            end
            if (popEn_s) begin
                rdPtr_r <= bumpPtr(rdPtr_r);
            end
            case ({pushEn_s, popEn_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/msdf_tree_sched.sv
// ---------------------------------------------------------------------------
// msdf_tree_sched
// Shares one MSDF adder tree between NUM_REQ requesters. A round-robin grant
// hands the tree to one requester for exactly TARGET_PRECISION digits; the
// owner's tag is queued so that the tree's in-order result digits can be
// labelled with their requester on the way out.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_dataInArray      per-requester operand digit vectors (slice r = req r)
//   req_pValidArray      per-requester digit valid
//   req_readyArray       per-requester digit accepted
//   tree_dataInArray_0   operand digits to the tree
//   tree_pValidArray_0   per-lane valid to the tree
//   tree_readyArray_0    per-lane ready from the tree
//   tree_dataOutArray_0  tree result digit
//   tree_validArray_0    tree result valid
//   tree_nReadyArray_0   ready back to the tree
//   dataOutArray_0       result digit
//   validArray_0         result valid
//   nReadyArray_0        downstream ready
//   tagOut               requester owning the current result digit
//   lastOut              final digit of a result stream
// ---------------------------------------------------------------------------
module msdf_tree_sched
    import msdf_tree_sched_pkg::*;
#(
    parameter int TARGET_PRECISION = 25,
    parameter int TREE_DEPTH       = 3,
    parameter int TREE_WIDTH       = 32'd1 << TREE_DEPTH,
    parameter int NUM_REQ          = 4,
    parameter int TAG_DEPTH        = 4,
    localparam int TAG_W           = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ*DIGIT_W*TREE_WIDTH-1:0] req_dataInArray,
    input  logic [NUM_REQ-1:0]                    req_pValidArray,
    output logic [NUM_REQ-1:0]                    req_readyArray,
    output logic [DIGIT_W*TREE_WIDTH-1:0]         tree_dataInArray_0,
    output logic [TREE_WIDTH-1:0]                 tree_pValidArray_0,
    input  logic [TREE_WIDTH-1:0]                 tree_readyArray_0,
    input  logic [DIGIT_W-1:0]                    tree_dataOutArray_0,
    input  logic                                  tree_validArray_0,
    output logic                                  tree_nReadyArray_0,
    output logic [DIGIT_W-1:0]                    dataOutArray_0,
    output logic                                  validArray_0,
    input  logic                                  nReadyArray_0,
    output logic [TAG_W-1:0]                      tagOut,
    output logic                                  lastOut
);

    localparam int SLICE_W = DIGIT_W * TREE_WIDTH;
    localparam int CNT_W   = clog2(TARGET_PRECISION) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TARGET_PRECISION - 1);
    localparam logic [TAG_W-1:0] REQ_LAST = TAG_W'(NUM_REQ - 1);
    localparam logic [TAG_W:0]   REQ_NUM  = (TAG_W + 1)'(NUM_REQ);

    schedState_t        state_r;
    schedState_t        nextState_s;
    logic [TAG_W-1:0]   grant_r;
    logic [TAG_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   inCnt_r;
    logic [CNT_W-1:0]   outCnt_r;

    logic [SLICE_W-1:0] reqSlice_s [NUM_REQ];
    logic               rrFound_s;
    logic [TAG_W-1:0]   rrIdx_s;
    logic               grantReq_s;
    logic               accept_s;
    logic               lastIn_s;

    logic               fifoFull_s;
    logic               fifoEmpty_s;
    logic [TAG_W-1:0]   fifoHead_s;
    logic               resValid_s;
    logic               outHs_s;
    logic               lastOut_s;
    logic               pop_s;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
        assign reqSlice_s[r] = req_dataInArray[r*SLICE_W +: SLICE_W];
    end

    // Round-robin search: first valid requester at or after ptr_r, wrapping.
    always_comb begin
        logic [TAG_W:0] cand;
        rrFound_s = 1'b0;
        rrIdx_s   = {TAG_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_r} + (TAG_W + 1)'(i);
            cand = (cand >= REQ_NUM) ? cand - REQ_NUM : cand;
            if (!rrFound_s && req_pValidArray[cand[TAG_W-1:0]]) begin
                rrFound_s = 1'b1;
                rrIdx_s   = cand[TAG_W-1:0];
            end else begin
                rrFound_s = rrFound_s;
                rrIdx_s   = rrIdx_s;
            end
        end
    end

    // A full tag FIFO blocks a grant even if the head pops this cycle.
    assign grantReq_s = !rst && (state_r == ST_IDLE) && rrFound_s && !fifoFull_s;
    assign accept_s   = !rst && (state_r == ST_ISSUE) && req_pValidArray[grant_r]
                        && (&tree_readyArray_0);
    assign lastIn_s   = accept_s && (inCnt_r == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state: grant opens a stream, the final accepted digit closes it.
    always_comb begin
        case (state_r)
            ST_IDLE:  nextState_s = grantReq_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: nextState_s = lastIn_s ? ST_IDLE : ST_ISSUE;
            default:  nextState_s = ST_IDLE;
        endcase
    end

    // FSM outputs: only the granted requester is routed to the tree; reset
    // forces the idle (all-zero) drive.
    always_comb begin
        req_readyArray     = {NUM_REQ{1'b0}};
        tree_dataInArray_0 = {SLICE_W{1'b0}};
        tree_pValidArray_0 = {TREE_WIDTH{1'b0}};
        case (rst ? ST_IDLE : state_r)
            ST_IDLE: begin
                req_readyArray     = {NUM_REQ{1'b0}};
                tree_dataInArray_0 = {SLICE_W{1'b0}};
                tree_pValidArray_0 = {TREE_WIDTH{1'b0}};
            end
            ST_ISSUE: begin
                tree_dataInArray_0      = reqSlice_s[grant_r];
                tree_pValidArray_0      = {TREE_WIDTH{req_pValidArray[grant_r]}};
                req_readyArray[grant_r] = accept_s;
            end
            default: begin
                req_readyArray     = {NUM_REQ{1'b0}};
                tree_dataInArray_0 = {SLICE_W{1'b0}};
                tree_pValidArray_0 = {TREE_WIDTH{1'b0}};
            end
        endcase
    end

    // Grant owner, input digit counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r <= {TAG_W{1'b0}};
            ptr_r   <= {TAG_W{1'b0}};
            inCnt_r <= {CNT_W{1'b0}};
        end else if (grantReq_s) begin
            grant_r <= rrIdx_s;
            inCnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            inCnt_r <= inCnt_r + CNT_W'(1);
            if (lastIn_s) begin
                ptr_r <= (grant_r == REQ_LAST) ? {TAG_W{1'b0}} : grant_r + TAG_W'(1);
            end
        end
    end

    // Output digit counter; cleared by the handshake that carries lastOut.
    always_ff @(posedge clk) begin
        if (rst) begin
            outCnt_r <= {CNT_W{1'b0}};
        end else if (outHs_s) begin
            outCnt_r <= lastOut_s ? {CNT_W{1'b0}} : outCnt_r + CNT_W'(1);
        end
    end

    // Result path: tree digits only count while some tag is in flight.
    assign resValid_s = !rst && tree_validArray_0 && !fifoEmpty_s;
    assign outHs_s    = resValid_s && nReadyArray_0;
    assign lastOut_s  = resValid_s && (outCnt_r == CNT_LAST);
    assign pop_s      = lastOut_s && nReadyArray_0;

    assign dataOutArray_0     = rst ? {DIGIT_W{1'b0}} : tree_dataOutArray_0;
    assign validArray_0       = resValid_s;
    assign tree_nReadyArray_0 = !rst && nReadyArray_0 && !fifoEmpty_s;
    assign tagOut             = (rst || fifoEmpty_s) ? {TAG_W{1'b0}} : fifoHead_s;
    assign lastOut            = lastOut_s;

    msdf_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tagFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grantReq_s),
        .pushData (rrIdx_s),
        .pop      (pop_s),
        .popData  (fifoHead_s),
        .full     (fifoFull_s),
        .empty    (fifoEmpty_s)
    );

endmodule

// File: doc/msdf_tree_sched.md
MSDF_TREE_SCHED -- requirements
Module: msdf_tree_sched

Interface
REQ-001 SHALL have parameter TARGET_PRECISION, default 25, meaning digits per operand stream.
REQ-002 SHALL have parameter TREE_DEPTH, default 3, meaning depth of the shared adder tree.
REQ-003 SHALL have parameter TREE_WIDTH, default 2**TREE_DEPTH, meaning operands per tree issue.
REQ-004 SHALL have parameter NUM_REQ, default 4, meaning requester count; TAG_W = max(1, clog2(NUM_REQ)).
REQ-005 SHALL have parameter TAG_DEPTH, default 4, meaning maximum number of operand sets in flight inside the tree.
REQ-006 SHALL have ports, in order:
- clk  in  1  clock; the single clock.
- rst  in  1  reset; synchronous, active-high.
- req_dataInArray  in  NUM_REQ*3*TREE_WIDTH  digit vector per requester; requester r occupies slice r.
- req_pValidArray  in  NUM_REQ  requester digit valid.
- req_readyArray  out  NUM_REQ  requester digit accepted.
- tree_dataInArray_0  out  3*TREE_WIDTH  to tree input.
- tree_pValidArray_0  out  TREE_WIDTH  to tree input valid.
- tree_readyArray_0  in  TREE_WIDTH  from tree input ready.
- tree_dataOutArray_0  in  3  tree result digit.
- tree_validArray_0  in  1  tree result valid.
- tree_nReadyArray_0  out  1  backpressure to tree.
- dataOutArray_0  out  3  result digit.
- validArray_0  out  1  result valid.
- nReadyArray_0  in  1  downstream ready.
- tagOut  out  TAG_W  requester owning the current result digit.
- lastOut  out  1  final digit of a result stream.

Function
REQ-007 SHALL treat a digit as an opaque 3-bit value; no arithmetic on digits.
REQ-008 SHALL implement FSM states IDLE and ISSUE.
REQ-009 IDLE: if any req_pValidArray bit is set and the tag FIFO is not full, SHALL select requester g by round-robin starting at pointer ptr, register g, push g into the tag FIFO, clear in_cnt, and enter ISSUE next cycle.
REQ-010 IDLE: SHALL drive tree_pValidArray_0 = 0 and req_readyArray = 0; the grant cycle accepts no digit.
REQ-011 ISSUE: SHALL drive tree_dataInArray_0 = slice g and every tree_pValidArray_0 bit = req_pValidArray[g].
REQ-012 ISSUE: a digit SHALL be accepted when req_pValidArray[g] is high and all tree_readyArray_0 bits are high; req_readyArray[g] SHALL equal this accept term, and all other requester ready bits SHALL be 0.
REQ-013 On each accept SHALL increment in_cnt; the accept at in_cnt = TARGET_PRECISION-1 SHALL return to IDLE and set ptr = (g+1) mod NUM_REQ.
REQ-014 Grant SHALL be held for exactly TARGET_PRECISION accepted digits regardless of other requests; there is no preemption.
REQ-015 The tree emits exactly TARGET_PRECISION result digits per issued operand set, in issue order.
REQ-016 Result path is combinational: dataOutArray_0 = tree_dataOutArray_0; validArray_0 = tree_validArray_0 AND FIFO not empty; tree_nReadyArray_0 = nReadyArray_0 AND FIFO not empty.
REQ-017 tagOut SHALL equal the FIFO head; out_cnt SHALL count output handshakes (validArray_0 AND nReadyArray_0).
REQ-018 lastOut SHALL be high when out_cnt = TARGET_PRECISION-1 and validArray_0 is high; that handshake SHALL pop the FIFO and clear out_cnt.
REQ-019 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a full FIFO blocks a grant; an empty FIFO gates the result valid.
REQ-020 Counters SHALL be ceil(log2(TARGET_PRECISION))+1 bits wide; ptr SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-021 When rst is high at a clk edge, the block SHALL enter IDLE with ptr = 0, g = 0, in_cnt = 0, out_cnt = 0, and the FIFO empty.
REQ-022 While in reset, all outputs SHALL be 0 (data, valid, ready, tagOut, lastOut).
REQ-023 Reset mid-stream SHALL discard the partial operand and all in-flight tags; the tree is reset by the same rst.

Structure
REQ-024 The shared package/header SHALL hold DIGIT_W = 3, the FSM state encodings, and the clog2 function.
REQ-025 The tag FIFO SHALL be a sub-module msdf_tag_fifo (parameters WIDTH and DEPTH; push/pop/full/empty; same-cycle push and pop allowed).
REQ-026 The round-robin select SHALL be combinational logic inside msdf_tree_sched.

Verification (TARGET_PRECISION=25, NUM_REQ=4, TAG_DEPTH=4)
REQ-027 Single requester 1 streaming 25 valid digits with tree always ready -> grant at cycle 1, 25 accepts on cycles 2-26, IDLE at cycle 27; the 25 results carry tagOut=1 and lastOut is high on the 25th.
REQ-028 Requesters 0-3 all valid from reset -> grant order 0,1,2,3,0, each holding exactly 25 accepts.
REQ-029 Tree ready toggling every other cycle during ISSUE -> requester ready mirrors it; exactly 25 accepts; no digit duplicated or lost.
REQ-030 nReadyArray_0 held low for 200 cycles with all requesters valid -> 4 grants, then no further grant while the FIFO is full; grants resume after the first lastOut pop.
REQ-031 rst asserted after 10 accepts of requester 2 -> next cycle IDLE, ptr=0, FIFO empty, all outputs 0; the following grant goes to the lowest valid index.
REQ-032 Last output handshake coincides with a grant-cycle push -> FIFO occupancy unchanged and tagOut advances to the next tag.
